// File: rtl/disp_pkg.sv
// Shared definitions for the display update arbiter and the 7-segment display block:
// FSM encoding, digit/mode widths and the round-robin pick helper.
package disp_pkg;

    localparam int DIGIT_W = 4;
    localparam int NDIGIT  = 4;
    localparam int DATA_W  = DIGIT_W * NDIGIT;
    localparam int CNT_W   = 16;

    localparam logic [1:0] MODE_0 = 2'd0;
    localparam logic [1:0] MODE_1 = 2'd1;
    localparam logic [1:0] MODE_2 = 2'd2;
    localparam logic [1:0] MODE_3 = 2'd3;

    localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 4'd15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        GAP       = 3'd4
    } state_t;

    // Two-way round robin: a lone request wins, a tie goes to the index that did not win last.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic pick;
        if (req == 2'b11) begin
            pick = ~last;
        end else if (req[1]) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/disp_update_arbiter_if.sv
// Requester and display-engine signal bundle; the arbiter takes the slave side,
// the surrounding game logic / engine model take the master side.
interface disp_update_arbiter_if;
    import disp_pkg::*;

    logic              req0;
    logic [DATA_W-1:0] data0;
    logic [1:0]        mode0;
    logic              done0;

    logic              req1;
    logic [DATA_W-1:0] data1;
    logic [1:0]        mode1;
    logic              done1;

    logic              disp_set;
    logic              disp_start;
    logic [DATA_W-1:0] disp_data;
    logic [1:0]        disp_mode;
    logic              disp_ss;

    modport master (
        output req0, data0, mode0,
        output req1, data1, mode1,
        output disp_ss,
        input  done0, done1,
        input  disp_set, disp_start, disp_data, disp_mode
    );

    modport slave (
        input  req0, data0, mode0,
        input  req1, data1, mode1,
        input  disp_ss,
        output done0, done1,
        output disp_set, disp_start, disp_data, disp_mode
    );

endinterface

// File: rtl/disp_update_arbiter_rr_arb2.sv
// Two-way round-robin grant with a registered last-owner; the owner only
// moves when the parent confirms the grant with load_i.
module rr_arb2
    import disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       load_i,
    output logic       gnt_o,
    output logic       any_o,
    output logic       owner_o
);

    logic owner_q;
    logic owner_d;

    // Grant selection and next owner
    always_comb begin
        gnt_o = rr_pick(req_i, owner_q);
        any_o = |req_i;
        if (load_i) begin
            owner_d = gnt_o;
        end else begin
            owner_d = owner_q;
        end
    end

    // Last-owner register; resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= 1'b1;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign owner_o = owner_q;

endmodule

// File: rtl/disp_update_arbiter.sv
// Shares one SPI 7-segment engine between two requesters: grants round-robin,
// issues set/start, follows the engine's ss line and returns a done pulse.
module disp_update_arbiter
    import disp_pkg::*;
#(
    parameter int START_CYC   = 4,
    parameter int TIMEOUT_CYC = 65535,
    parameter int GAP_CYC     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    disp_update_arbiter_if.slave  bus,
    output logic                  busy,
    output logic                  owner,
    output logic                  timeout_err
);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = (GAP_CYC == 0) ? 16'd0 : CNT_W'(GAP_CYC - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              set_q, set_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        mode_q, mode_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              busy_q, busy_d;
    logic              terr_q, terr_d;

    logic              arb_load_s;
    logic              gnt_s;
    logic              any_req_s;
    logic              owner_s;
    logic              gap_end_s;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   ({bus.req1, bus.req0}),
        .load_i  (arb_load_s),
        .gnt_o   (gnt_s),
        .any_o   (any_req_s),
        .owner_o (owner_s)
    );

    // Next-state, counter, latch and registered-output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        set_d      = 1'b0;
        data_d     = data_q;
        mode_d     = mode_q;
        terr_d     = terr_q;
        arb_load_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    state_d    = ISSUE;
                    cnt_d      = 16'd0;
                    set_d      = 1'b1;
                    arb_load_s = 1'b1;
                    data_d     = gnt_s ? bus.data1 : bus.data0;
                    mode_d     = gnt_s ? bus.mode1 : bus.mode0;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (cnt_q == START_LAST) begin
                    state_d = WAIT_LOW;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    set_d = 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!bus.disp_ss) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = 16'd0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = GAP;
                    cnt_d   = 16'd0;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_HIGH: begin
                if (bus.disp_ss) begin
                    state_d = GAP;
                    cnt_d   = 16'd0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = GAP;
                    cnt_d   = 16'd0;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        // done is registered, so it is raised when the next cycle is the final GAP cycle
        gap_end_s = (state_d == GAP) && (cnt_d >= GAP_LAST);
        done0_d   = gap_end_s && !owner_s;
        done1_d   = gap_end_s && owner_s;
        busy_d    = (state_d != IDLE);
    end

    // State and output registers; reset abandons any transfer without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            set_q   <= 1'b0;
            data_q  <= {DATA_W{1'b0}};
            mode_q  <= 2'b00;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            set_q   <= set_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.disp_set   = set_q;
    assign bus.disp_start = set_q;
    assign bus.disp_data  = data_q;
    assign bus.disp_mode  = mode_q;
    assign bus.done0      = done0_q;
    assign bus.done1      = done1_q;
    assign busy           = busy_q;
    assign owner          = owner_s;
    assign timeout_err    = terr_q;

endmodule

// File: doc/disp_update_arbiter.md
Name: disp_update_arbiter

Overview:
- Shares one SPI 7-segment display engine between two independent requesters, e.g. a score counter and a game timer.
- Latches the granted requester's 4-digit word and 2-bit mode, then drives the engine's set/start inputs.
- Tracks the SPI transfer by monitoring the engine's ss line, then returns a done pulse to the winner.
- Sits between the game logic and the display block; the engine is the only SPI master on the bus.

Parameters:
- START_CYC, 4, cycles that disp_set/disp_start stay high per issue (1..255).
- TIMEOUT_CYC, 65535, max cycles waited for each ss edge before abort (16-bit counter).
- GAP_CYC, 16, idle cycles enforced after ss returns high before the next grant (0..255).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- req0  input  1  requester 0 level request; held until done0
- data0  input  16  requester 0 digits {d3,d2,d1,d0}, 4 bits each
- mode0  input  2  requester 0 display mode
- done0  output  1  one-cycle completion pulse to requester 0
- req1, data1, mode1, done1  as above for requester 1
- disp_set  output  1  to engine set
- disp_start  output  1  to engine start
- disp_data  output  16  to engine digit input
- disp_mode  output  2  to engine mode
- disp_ss  input  1  engine slave-select, active-low during transfer
- busy  output  1  high in any state except IDLE
- owner  output  1  index of current/last grant
- timeout_err  output  1  sticky; set on any timeout, cleared only by rst

Behaviour:
- Reset values: disp_set=0, disp_start=0, disp_data=0, disp_mode=0, done0=done1=0, busy=0, owner=1, timeout_err=0, state=IDLE, all counters 0.
- Reset has priority and may occur mid-transfer: return to IDLE immediately with no done pulse. The engine is reset by the same rst.
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, GAP.
- IDLE -> ISSUE: on a cycle where any req is high.
  - Arbitration is round-robin. With a single request, grant it. With both, grant the index != owner, so after reset req0 wins a tie.
  - On grant, register owner, latch disp_data/disp_mode from the winner, and load the counter.
- ISSUE:
  - disp_set = disp_start = 1 for exactly START_CYC cycles, then both drop to 0 and the FSM moves to WAIT_LOW.
  - disp_data and disp_mode are stable from the grant cycle until the next grant. Requester input changes after grant are ignored.
- WAIT_LOW: wait for disp_ss == 0, sampled.
  - If ss is already low on entry, advance next cycle.
  - -> WAIT_HIGH.
- WAIT_HIGH: wait for disp_ss == 1, then -> GAP.
- Timeout: in WAIT_LOW or WAIT_HIGH, if the counter reaches TIMEOUT_CYC, set timeout_err and go to GAP. The done pulse is still issued so the requester is never starved.
- GAP: count GAP_CYC cycles (0 means a single pass-through cycle).
  - Pulse done[owner] for one cycle on GAP exit, then -> IDLE.
  - A new grant occurs no earlier than the cycle after the done pulse.
- Loser's request stays pending and is served next. No request is dropped.
- A req that falls before done has no effect on the in-flight transfer. It still gets its done pulse.
- busy = (state != IDLE).

Decomposition:
- Shared package disp_pkg holds:
  - state encoding localparams (IDLE=0..GAP=4)
  - DIGIT_W=4 and NDIGIT=4, so the data width is 16
  - mode encodings MODE_0..MODE_3
  - DIGIT_BLANK=4'd15, shared with the display block
- One natural sub-module, rr_arb2: a 2-way round-robin grant with registered last-owner.
- Timer, FSM and latch stay in the top level.

Test Plan:
- Single request: req0=1, data0=16'h3FFF, mode0=0, engine model drives ss low 10 cycles after start and high 400 cycles later.
  -> disp_set/disp_start high exactly 4 cycles, disp_data=16'h3FFF, one done0 pulse 16 cycles after ss rises, done1 never.
- Tie: req0 and req1 rise in the same cycle with data 16'h3210 and 16'h965A.
  -> first grant owner=0, disp_data=16'h3210; second grant owner=1, disp_data=16'h965A. The two grants are separated by at least GAP_CYC+1 idle cycles.
- Fairness: both requests held continuously for 6 transfers -> owner sequence 0,1,0,1,0,1, three done pulses each.
- Input change after grant: grant req1 with data1=16'h1A3B, mode1=3, then change data1 to 16'h0000 during ISSUE.
  -> disp_data stays 16'h1A3B through WAIT_HIGH.
- Timeout: TIMEOUT_CYC set to 100, disp_ss held high.
  -> after 100 cycles in WAIT_LOW, timeout_err=1, done0 pulses, FSM returns to IDLE, timeout_err stays 1 on later good transfers.
- Reset mid-operation: assert rst for 1 cycle during WAIT_HIGH.
  -> next cycle all outputs at reset values, no done pulse, owner=1; the next tie goes to req0.
